// File: rtl/cache_pkg.sv
// Shared state encoding and address-split widths for the direct-mapped data cache.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITE_THRU,
      FILL,
      STORE_DONE
   } cache_state_t;

   function automatic int unsigned offset_bits(input int unsigned block_size);
      return $clog2(block_size);
   endfunction

   function automatic int unsigned index_bits(input int unsigned sets);
      return $clog2(sets);
   endfunction

   localparam int unsigned DEF_SETS       = 8;
   localparam int unsigned DEF_BLOCK_SIZE = 4;
   localparam int unsigned OFFSET_BITS    = offset_bits(DEF_BLOCK_SIZE);
   localparam int unsigned INDEX_BITS     = index_bits(DEF_SETS);
   localparam int unsigned TAG_BITS       = 30 - OFFSET_BITS - INDEX_BITS;

endpackage

// File: rtl/dcache_line_store.sv
// Tag, valid and data arrays: combinational read, word or block write, async valid clear.
module dcache_line_store
   import cache_pkg::*;
#(
   parameter int unsigned SETS       = DEF_SETS,
   parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE
) (
   input  logic                                                  Clk,
   input  logic                                                  Rst,
   input  logic [index_bits(SETS)-1:0]                           rd_index,
   input  logic [offset_bits(BLOCK_SIZE)-1:0]                    rd_offset,
   output logic                                                  rd_valid,
   output logic [30-offset_bits(BLOCK_SIZE)-index_bits(SETS)-1:0] rd_tag,
   output logic [31:0]                                           rd_word,
   input  logic                                                  word_we,
   input  logic [index_bits(SETS)-1:0]                           word_index,
   input  logic [offset_bits(BLOCK_SIZE)-1:0]                    word_offset,
   input  logic [31:0]                                           word_data,
   input  logic                                                  block_we,
   input  logic [index_bits(SETS)-1:0]                           block_index,
   input  logic [30-offset_bits(BLOCK_SIZE)-index_bits(SETS)-1:0] block_tag,
   input  logic [32*BLOCK_SIZE-1:0]                              block_data
);

   localparam int unsigned OW = offset_bits(BLOCK_SIZE);
   localparam int unsigned TW = 30 - OW - index_bits(SETS);

   logic [SETS-1:0] valid_q;
   logic [TW-1:0]   tag_q  [SETS];
   logic [31:0]     data_q [SETS][BLOCK_SIZE];

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         valid_q <= '0;
      else if (block_we)
         valid_q[block_index] <= 1'b1;
   end

   // Payload arrays carry no reset; the valid bits alone gate their use.
   always_ff @(posedge Clk) begin
      if (block_we) begin
         tag_q[block_index] <= block_tag;
         for (int unsigned w = 0; w < BLOCK_SIZE; w++)
            data_q[block_index][w[OW-1:0]] <= block_data[32*w +: 32];
      end else if (word_we) begin
         data_q[word_index][word_offset] <= word_data;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_word  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, write-allocate data cache with fill/write-through handshake to memory.
module data_cache
   import cache_pkg::*;
#(
   parameter int unsigned SETS       = DEF_SETS,
   parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [31:0]               Address,
   input  logic                      MemRead,
   input  logic                      MemWrite,
   input  logic [31:0]               Write_data,
   output logic [31:0]               Read_data,
   output logic                      Stall,
   output logic [31:0]               MemAddress,
   output logic                      MemReadMiss,
   output logic                      MemWriteThrough,
   output logic [31:0]               MemWrite_data,
   input  logic [32*BLOCK_SIZE-1:0]  MemRead_data,
   input  logic                      MemReadReady,
   input  logic                      MemWriteReady
);

   localparam int unsigned OW = offset_bits(BLOCK_SIZE);
   localparam int unsigned IW = index_bits(SETS);
   localparam int unsigned TW = 30 - OW - IW;

   cache_state_t state, state_next;

   logic [31:2]   lat_addr;
   logic [31:0]   lat_data;
   logic          lat_miss, lat_store;
   logic          accept, hit, word_we, block_we;
   logic          rd_valid;
   logic [TW-1:0] rd_tag;
   logic [31:0]   rd_word;
   logic          addr_lsb_unused;

   assign addr_lsb_unused = ^Address[1:0];

   dcache_line_store #(
      .SETS       (SETS),
      .BLOCK_SIZE (BLOCK_SIZE)
   ) u_lines (
      .Clk         (Clk),
      .Rst         (Rst),
      .rd_index    (Address[OW+IW+1:OW+2]),
      .rd_offset   (Address[OW+1:2]),
      .rd_valid    (rd_valid),
      .rd_tag      (rd_tag),
      .rd_word     (rd_word),
      .word_we     (word_we),
      .word_index  (lat_addr[OW+IW+1:OW+2]),
      .word_offset (lat_addr[OW+1:2]),
      .word_data   (lat_data),
      .block_we    (block_we),
      .block_index (lat_addr[OW+IW+1:OW+2]),
      .block_tag   (lat_addr[31:OW+IW+2]),
      .block_data  (MemRead_data)
   );

   assign hit = rd_valid && (rd_tag == Address[31:OW+IW+2]);

   always_comb begin
      state_next      = state;
      accept          = 1'b0;
      word_we         = 1'b0;
      block_we        = 1'b0;
      Stall           = 1'b0;
      Read_data       = '0;
      MemReadMiss     = 1'b0;
      MemWriteThrough = 1'b0;
      MemAddress      = '0;
      MemWrite_data   = '0;
      unique case (state)
         IDLE: begin
            if (MemWrite) begin
               Stall      = 1'b1;
               accept     = 1'b1;
               state_next = WRITE_THRU;
            end else if (MemRead) begin
               if (hit) begin
                  Read_data = rd_word;
               end else begin
                  Stall      = 1'b1;
                  accept     = 1'b1;
                  state_next = FILL;
               end
            end
         end
         WRITE_THRU: begin
            Stall           = 1'b1;
            MemWriteThrough = 1'b1;
            MemAddress      = {lat_addr, 2'b00};
            MemWrite_data   = lat_data;
            if (MemWriteReady) begin
               // A store miss skips the word update: the fill returns memory already holding it.
               if (lat_miss) begin
                  state_next = FILL;
               end else begin
                  word_we    = 1'b1;
                  state_next = STORE_DONE;
               end
            end
         end
         FILL: begin
            Stall       = 1'b1;
            MemReadMiss = 1'b1;
            MemAddress  = {lat_addr[31:OW+2], {(OW+2){1'b0}}};
            if (MemReadReady) begin
               block_we   = 1'b1;
               state_next = lat_store ? STORE_DONE : IDLE;
            end
         end
         STORE_DONE: state_next = IDLE;
         default:    state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= IDLE;
         lat_addr  <= '0;
         lat_data  <= '0;
         lat_miss  <= 1'b0;
         lat_store <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            lat_addr  <= Address[31:2];
            lat_data  <= Write_data;
            lat_miss  <= ~hit;
            lat_store <= MemWrite;
         end
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: the bench plays data_memory by hand with fixed blocks.
module tb_data_cache;

   logic         Clk = 1'b0;
   logic         Rst;
   logic [31:0]  Address;
   logic         MemRead, MemWrite;
   logic [31:0]  Write_data;
   logic [31:0]  Read_data;
   logic         Stall;
   logic [31:0]  MemAddress;
   logic         MemReadMiss, MemWriteThrough;
   logic [31:0]  MemWrite_data;
   logic [127:0] MemRead_data;
   logic         MemReadReady, MemWriteReady;

   int compared   = 0;
   int mismatched = 0;

   always #5 Clk = ~Clk;

   data_cache #(
      .SETS       (8),
      .BLOCK_SIZE (4)
   ) dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .Address         (Address),
      .MemRead         (MemRead),
      .MemWrite        (MemWrite),
      .Write_data      (Write_data),
      .Read_data       (Read_data),
      .Stall           (Stall),
      .MemAddress      (MemAddress),
      .MemReadMiss     (MemReadMiss),
      .MemWriteThrough (MemWriteThrough),
      .MemWrite_data   (MemWrite_data),
      .MemRead_data    (MemRead_data),
      .MemReadReady    (MemReadReady),
      .MemWriteReady   (MemWriteReady)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Entered with the DUT in FILL; returns one cycle after the ready pulse.
   task automatic do_fill(input string tag, input logic [31:0] exp_addr, input logic [127:0] blk);
      chk({tag, "_miss"}, {31'd0, MemReadMiss}, 32'd1);
      chk({tag, "_addr"}, MemAddress, exp_addr);
      chk({tag, "_nowt"}, {31'd0, MemWriteThrough}, 32'd0);
      step();
      chk({tag, "_hold"}, {31'd0, MemReadMiss}, 32'd1);
      MemRead_data = blk;
      MemReadReady = 1'b1;
      #1;
      chk({tag, "_stall_rdy"}, {31'd0, Stall}, 32'd1);
      step();
      MemReadReady = 1'b0;
      MemRead_data = '0;
      #1;
      chk({tag, "_drop"}, {31'd0, MemReadMiss}, 32'd0);
   endtask

   // Entered with the DUT in WRITE_THRU; returns one cycle after the ready pulse.
   task automatic do_write(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_data);
      chk({tag, "_wt"}, {31'd0, MemWriteThrough}, 32'd1);
      chk({tag, "_addr"}, MemAddress, exp_addr);
      chk({tag, "_data"}, MemWrite_data, exp_data);
      chk({tag, "_nomiss"}, {31'd0, MemReadMiss}, 32'd0);
      step();
      MemWriteReady = 1'b1;
      #1;
      chk({tag, "_stall_rdy"}, {31'd0, Stall}, 32'd1);
      step();
      MemWriteReady = 1'b0;
      #1;
      chk({tag, "_drop"}, {31'd0, MemWriteThrough}, 32'd0);
   endtask

   initial begin
      Rst           = 1'b1;
      Address       = '0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      Write_data    = '0;
      MemRead_data  = '0;
      MemReadReady  = 1'b0;
      MemWriteReady = 1'b0;

      // 1: reset
      step();
      step();
      chk("rst_stall", {31'd0, Stall}, 32'd0);
      chk("rst_miss", {31'd0, MemReadMiss}, 32'd0);
      chk("rst_wt", {31'd0, MemWriteThrough}, 32'd0);
      chk("rst_rdata", Read_data, 32'd0);
      chk("rst_maddr", MemAddress, 32'd0);
      Rst = 1'b0;
      step();

      // 2: cold load miss on 0x14, then hits
      Address = 32'h14;
      MemRead = 1'b1;
      #1;
      chk("t2_stall_req", {31'd0, Stall}, 32'd1);
      chk("t2_miss_not_yet", {31'd0, MemReadMiss}, 32'd0);
      chk("t2_rdata_miss", Read_data, 32'd0);
      step();
      do_fill("t2_fill", 32'h10, {32'hA7, 32'hA6, 32'hA5, 32'hA4});
      chk("t2_rdata", Read_data, 32'hA5);
      chk("t2_nostall", {31'd0, Stall}, 32'd0);
      Address = 32'h18;
      #1;
      chk("t2_hit18", Read_data, 32'hA6);
      chk("t2_hit18_stall", {31'd0, Stall}, 32'd0);
      step();

      // 3: store hit 0xDEAD to 0x14
      MemRead    = 1'b0;
      MemWrite   = 1'b1;
      Address    = 32'h14;
      Write_data = 32'hDEAD;
      #1;
      chk("t3_stall_req", {31'd0, Stall}, 32'd1);
      chk("t3_wt_not_yet", {31'd0, MemWriteThrough}, 32'd0);
      step();
      do_write("t3_wr", 32'h14, 32'hDEAD);
      chk("t3_done_stall", {31'd0, Stall}, 32'd0);
      step();
      MemWrite = 1'b0;
      MemRead  = 1'b1;
      #1;
      chk("t3_hit14", Read_data, 32'hDEAD);
      chk("t3_hit14_stall", {31'd0, Stall}, 32'd0);
      step();

      // 4: conflict eviction 0x90 vs 0x14
      Address = 32'h90;
      #1;
      chk("t4_stall90", {31'd0, Stall}, 32'd1);
      step();
      do_fill("t4_fill90", 32'h90, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
      chk("t4_rdata90", Read_data, 32'hC0);
      Address = 32'h14;
      #1;
      chk("t4_stall14", {31'd0, Stall}, 32'd1);
      step();
      do_fill("t4_fill10", 32'h10, {32'hA7, 32'hA6, 32'hDEAD, 32'hA4});
      chk("t4_rdata14", Read_data, 32'hDEAD);
      chk("t4_nostall", {31'd0, Stall}, 32'd0);
      step();

      // 5: store miss 0xBEEF to 0x28
      MemRead    = 1'b0;
      MemWrite   = 1'b1;
      Address    = 32'h28;
      Write_data = 32'hBEEF;
      #1;
      chk("t5_stall_req", {31'd0, Stall}, 32'd1);
      step();
      do_write("t5_wr", 32'h28, 32'hBEEF);
      do_fill("t5_fill", 32'h20, {32'hD3, 32'hBEEF, 32'hD1, 32'hD0});
      chk("t5_done_stall", {31'd0, Stall}, 32'd0);
      step();
      MemWrite = 1'b0;
      MemRead  = 1'b1;
      #1;
      chk("t5_hit28", Read_data, 32'hBEEF);
      chk("t5_hit28_stall", {31'd0, Stall}, 32'd0);
      step();

      // 6: reset in the middle of a fill
      Address = 32'h38;
      step();
      chk("t6_in_fill", {31'd0, MemReadMiss}, 32'd1);
      Rst     = 1'b1;
      MemRead = 1'b0;
      #1;
      chk("t6_miss_drop", {31'd0, MemReadMiss}, 32'd0);
      chk("t6_maddr", MemAddress, 32'd0);
      chk("t6_stall", {31'd0, Stall}, 32'd0);
      step();
      Rst     = 1'b0;
      MemRead = 1'b1;
      Address = 32'h18;
      #1;
      chk("t6_cold_stall", {31'd0, Stall}, 32'd1);
      chk("t6_cold_rdata", Read_data, 32'd0);
      step();
      do_fill("t6_fill", 32'h10, {32'hA7, 32'hA6, 32'hDEAD, 32'hA4});
      chk("t6_rdata", Read_data, 32'hA6);
      step();
      MemRead = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, write-allocate data cache between the pipeline's memory stage and `data_memory`. It serves load and store hits from a local line store and stalls the pipeline on misses and write-throughs. It drives the memory's request/ready handshake: `ReadMiss` and `MemWriteThrough` go out, and `ReadReady` and `WriteReady` come back. It acts as the initiator for the block-fill and word-write transactions that `data_memory` answers.

## Interface
- `SETS`, default 8: number of lines; must be a power of 2.
- `BLOCK_SIZE`, default 4: words per line; must match `data_memory`.
- `Clk` in 1: clock.
- `Rst` in 1: reset; asynchronous, active-high.
- `Address` in 32: CPU byte address. Bits [1:0] are ignored.
- `MemRead` in 1: load request.
- `MemWrite` in 1: store request. Has priority if asserted together with `MemRead`.
- `Write_data` in 32: store data.
- `Read_data` out 32: load data. Driven only when a load hits; 0 otherwise.
- `Stall` out 1: pipeline must hold `Address`, `MemRead`, `MemWrite` and `Write_data` while high.
- `MemAddress` out 32: address to memory.
- `MemReadMiss` out 1: block-fill request.
- `MemWriteThrough` out 1: word-write request.
- `MemWrite_data` out 32: word to write.
- `MemRead_data` in 32*BLOCK_SIZE: returned block; word i occupies bits [32i+31:32i].
- `MemReadReady` in 1: one-cycle pulse; `MemRead_data` is valid in this cycle.
- `MemWriteReady` in 1: one-cycle pulse; the write is complete.

## Operation
- **Address split**
  - word offset = [log2(BLOCK_SIZE)+1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- **Hit** = valid[index] and tag match, evaluated only in IDLE.
- **States:** IDLE, WRITE_THRU, FILL, STORE_DONE.
- **IDLE**
  - Load hit: `Read_data` = the word, `Stall`=0, state stays IDLE.
  - Load miss: latch address; go to FILL.
  - Store (hit or miss): latch address and data, plus a `was_miss` flag; go to WRITE_THRU.
    - On a hit, the cache word is not written yet.
- **WRITE_THRU**
  - Outputs: `MemWriteThrough`=1, `MemAddress` = latched word address, `MemWrite_data` = latched data.
  - On `MemWriteReady`:
    - If hit: update the cache word, then go to STORE_DONE.
    - If miss: go to FILL.
- **FILL**
  - Outputs: `MemReadMiss`=1, `MemAddress` = latched address with the low log2(BLOCK_SIZE)+2 bits zeroed.
  - On `MemReadReady`: write the whole block, set tag, set valid.
    - For a load miss, go to IDLE; the retried load then hits.
    - For a store miss, go to STORE_DONE. The filled block already contains the stored word.
- **STORE_DONE**
  - `Stall`=0 for exactly one cycle; the store retires. Go to IDLE.
- **Request outputs**
  - `MemReadMiss` and `MemWriteThrough` are decoded from state only, so they drop on the edge that consumes the ready pulse. Memory therefore never sees a stale request when it returns to its idle state.
  - The two requests are never asserted together.
- **`Stall`** = 1 in IDLE when there is a store or a load miss, and in WRITE_THRU and FILL. `Stall` = 0 otherwise.
- **Eviction** of a conflicting line is silent; no writeback is needed because the cache is write-through.
- **Ready pulses** arriving in a state that does not expect them are ignored.

## Timing
- **Reset (asynchronous):**
  - state = IDLE
  - all valid bits = 0
  - `Stall`=0 when there is no request
  - `MemReadMiss`=0, `MemWriteThrough`=0
  - `MemAddress`=0, `MemWrite_data`=0, `Read_data`=0
- **Load hit:** 0 stall cycles.
- **Load miss:**
  - `MemReadMiss` rises the cycle after the request.
  - `Stall` stays high through the `MemReadReady` cycle.
  - The next cycle delivers `Read_data` with `Stall`=0.
- **Store hit:**
  - `MemWriteThrough` rises the cycle after the request.
  - `Stall` is high through the `MemWriteReady` cycle, then STORE_DONE follows.
- **Store miss:** the write-through transaction, then the fill, then STORE_DONE.
- **Reset mid-transaction:** the request is dropped immediately and nothing is retried. The memory must also be reset.

## Structure
- **Package `cache_pkg`:** state encoding, plus localparams `OFFSET_BITS`, `INDEX_BITS` and `TAG_BITS` derived from `SETS` and `BLOCK_SIZE`.
- **One sub-module, `dcache_line_store`:** tag, valid and data arrays.
  - Combinational read.
  - Ports for a single-word write and a full-block write.
  - Asynchronous clear of the valid bits.

## Test plan
All scenarios use SETS=8, BLOCK_SIZE=4, and memory words at 0x10..0x1C = 0xA4, 0xA5, 0xA6, 0xA7.

1. **Reset:** assert `Rst` with no request.
   - Require `Stall`=0, `MemReadMiss`=0, `MemWriteThrough`=0 and `Read_data`=0.
2. **Cold load miss, then hit:** load 0x14.
   - Require `MemReadMiss`=1 with `MemAddress`=0x10 until `MemReadReady`.
   - The next cycle: `Read_data`=0xA5, `Stall`=0.
   - Then load 0x18: `Read_data`=0xA6 with zero stall.
3. **Store hit:** store 0xDEAD to 0x14.
   - Require `MemWriteThrough`=1, `MemAddress`=0x14, `MemWrite_data`=0xDEAD.
   - After `MemWriteReady`, `Stall` is low for one cycle.
   - Then load 0x14: returns 0xDEAD with zero stall.
4. **Conflict eviction:**
   - Load 0x90 (same index as 0x14, different tag): requires a fill from 0x90.
   - Then load 0x14: misses again and refills from 0x10.
5. **Store miss:** store 0xBEEF to 0x28 on a cold line.
   - Require the write-through to 0x28 first, then a fill from 0x20, then STORE_DONE.
   - Then load 0x28: returns 0xBEEF with zero stall.
6. **Reset mid-fill:** pulse `Rst` while in FILL.
   - Require `MemReadMiss` to drop immediately.
   - Then load 0x18: misses (valid bits were cleared).
